// File: rtl/ro_race_arbiter.sv
// Runs NUM_CHAL races between counter paths A and B over consecutive challenges
// and packs the winner of each race into one response word.
module ro_race_arbiter #(
   parameter int NUM_CHAL = 8,
   parameter int CHAL_W   = 8,
   parameter int TIMEOUT  = 1023,
   parameter bit TIE_BIT  = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [CHAL_W-1:0]   seed,
   input  logic                fin_a,
   input  logic                fin_b,
   output logic                cnt_clear,
   output logic                cnt_run,
   output logic [CHAL_W-1:0]   challenge,
   output logic                busy,
   output logic                resp_valid,
   output logic [NUM_CHAL-1:0] resp_word,
   output logic                timeout_err
);

   localparam int IDX_W = (NUM_CHAL > 1) ? $clog2(NUM_CHAL) : 1;
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_RACE   = 3'd2;
   localparam logic [2:0] S_RECORD = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [CHAL_W-1:0]   chal_q, chal_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [NUM_CHAL-1:0] word_q, word_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;
   logic                clr2_q, clr2_d;
   logic                bit_q, bit_d;
   logic                terr_q, terr_d;

   always_comb begin
      state_d = state_q;
      chal_d  = chal_q;
      idx_d   = idx_q;
      word_d  = word_q;
      tmr_d   = tmr_q;
      clr2_d  = clr2_q;
      bit_d   = bit_q;
      terr_d  = terr_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               chal_d  = seed;
               idx_d   = '0;
               word_d  = '0;
               terr_d  = 1'b0;
               clr2_d  = 1'b0;
               state_d = S_CLEAR;
            end
         end
         // Second CLEAR cycle lets the stale registered finish flag flush out.
         S_CLEAR: begin
            tmr_d = '0;
            if (clr2_q) begin
               clr2_d  = 1'b0;
               state_d = S_RACE;
            end else begin
               clr2_d = 1'b1;
            end
         end
         S_RACE: begin
            tmr_d = tmr_q + TMR_W'(1);
            if (fin_a ^ fin_b) begin
               bit_d   = fin_a;
               state_d = S_RECORD;
            end else if (fin_a && fin_b) begin
               bit_d   = TIE_BIT;
               state_d = S_RECORD;
            end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
               bit_d   = TIE_BIT;
               terr_d  = 1'b1;
               state_d = S_RECORD;
            end
         end
         S_RECORD: begin
            for (int i = 0; i < NUM_CHAL; i++) begin
               if (idx_q == IDX_W'(i)) word_d[i] = bit_q;
            end
            chal_d = chal_q + CHAL_W'(1);
            if (idx_q == IDX_W'(NUM_CHAL - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_CLEAR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         chal_q  <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         tmr_q   <= '0;
         clr2_q  <= 1'b0;
         bit_q   <= 1'b0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         chal_q  <= chal_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         tmr_q   <= tmr_d;
         clr2_q  <= clr2_d;
         bit_q   <= bit_d;
         terr_q  <= terr_d;
      end
   end

   assign cnt_clear   = (state_q != S_RACE);
   assign cnt_run     = (state_q == S_RACE);
   assign busy        = (state_q != S_IDLE);
   assign resp_valid  = (state_q == S_DONE);
   assign challenge   = chal_q;
   assign resp_word   = word_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_ro_race_arbiter.sv
// Directed bench for ro_race_arbiter: two instances differing only in TIE_BIT,
// expected words queued at start and checked by a resp_valid monitor.
module tb_ro_race_arbiter;

   localparam int NC = 4;
   localparam int TO = 16;

   typedef struct {
      int k;      // race cycle (1-based) at which fins are driven; 0 = never
      bit a;
      bit b;
      bit stale;  // hold fin_a high while the counters are being cleared
   } race_t;

   typedef struct {
      logic [NC-1:0] w0;
      logic [NC-1:0] w1;
      logic          terr;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset, start, fin_a, fin_b;
   logic [7:0]    seed;
   logic          cnt_clear, cnt_run, busy, resp_valid, timeout_err;
   logic [7:0]    challenge;
   logic [NC-1:0] resp_word;
   logic          t1_clear, t1_run, t1_busy, t1_valid, t1_terr;
   logic [7:0]    t1_chal;
   logic [NC-1:0] resp_word1;

   int     n_vec = 0;
   int     n_bad = 0;
   int     cyc = 0;
   int     start_cyc;
   exp_t   q[$];
   race_t  rr[NC];
   logic [NC-1:0] last_word = '0;
   logic   last_terr = 1'b0;
   bit     chk_after = 0;

   ro_race_arbiter #(.NUM_CHAL(NC), .CHAL_W(8), .TIMEOUT(TO), .TIE_BIT(1'b0)) dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed),
      .fin_a(fin_a), .fin_b(fin_b), .cnt_clear(cnt_clear), .cnt_run(cnt_run),
      .challenge(challenge), .busy(busy), .resp_valid(resp_valid),
      .resp_word(resp_word), .timeout_err(timeout_err));

   ro_race_arbiter #(.NUM_CHAL(NC), .CHAL_W(8), .TIMEOUT(TO), .TIE_BIT(1'b1)) dut_t1 (
      .clk(clk), .reset(reset), .start(start), .seed(seed),
      .fin_a(fin_a), .fin_b(fin_b), .cnt_clear(t1_clear), .cnt_run(t1_run),
      .challenge(t1_chal), .busy(t1_busy), .resp_valid(t1_valid),
      .resp_word(resp_word1), .timeout_err(t1_terr));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic race_t mk(input int k, input bit a, input bit b, input bit s);
      race_t r;
      r.k = k; r.a = a; r.b = b; r.stale = s;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one word using rr[]; abort >= 0 resets the DUT in race cycle 2 of that race.
   task automatic run_word(input logic [7:0] sd, input int abort);
      exp_t e;
      int   n, len, s, l;
      check("hold_word", resp_word, last_word);
      check("hold_terr", timeout_err, last_terr);
      e.w0 = '0; e.w1 = '0; e.terr = 1'b0; s = 0;
      for (int i = 0; i < NC; i++) begin
         l = (rr[i].k == 0) ? TO : rr[i].k;
         s += 3 + l;
         if (rr[i].k == 0) begin
            e.terr = 1'b1;
            e.w1[i] = 1'b1;
         end else if (rr[i].a && rr[i].b) begin
            e.w1[i] = 1'b1;
         end else begin
            e.w0[i] = rr[i].a;
            e.w1[i] = rr[i].a;
         end
      end
      seed = sd;
      start = 1'b1;
      step();
      start = 1'b0;
      start_cyc = cyc;
      e.cyc = start_cyc + s + 0;
      if (abort < 0) q.push_back(e);
      check("terr_cleared_on_start", timeout_err, 0);
      for (int i = 0; i < NC; i++) begin
         n = 0;
         while (!cnt_run && n < 10) begin
            check("cnt_clear_before_race", cnt_clear, 1);
            if (rr[i].stale) fin_a = 1'b1;
            if (abort >= 0 && i == 0 && n == 0) begin
               start = 1'b1;
               seed = 8'h77;
            end
            step();
            start = 1'b0;
            n++;
         end
         fin_a = 1'b0;
         check("clear_cycles", n, (i == 0) ? 2 : 3);
         check("challenge", challenge, 8'(sd + 8'(i)));
         len = 0;
         while (cnt_run && len < 40) begin
            len++;
            if (len == rr[i].k) begin
               fin_a = rr[i].a;
               fin_b = rr[i].b;
            end
            if (abort == i && len == 2) reset = 1'b1;
            step();
            fin_a = 1'b0;
            fin_b = 1'b0;
            if (reset) begin
               reset = 1'b0;
               check("rst_busy", busy, 0);
               check("rst_word", resp_word, 0);
               check("rst_clear", cnt_clear, 1);
               check("rst_run", cnt_run, 0);
               check("rst_chal", challenge, 0);
               check("rst_terr", timeout_err, 0);
               repeat (NC * 20) step();
               last_word = '0;
               last_terr = 1'b0;
               return;
            end
         end
         check("race_len", len, (rr[i].k == 0) ? TO : rr[i].k);
      end
      n = 0;
      while (busy && n < 10) begin
         step();
         n++;
      end
      check("returned_idle", busy, 0);
      last_word = e.w0;
      last_terr = e.terr;
      step();
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (chk_after) begin
            check("valid_one_cycle", resp_valid, 0);
            check("idle_after_done", busy, 0);
            chk_after = 0;
         end
         if (resp_valid) begin
            if (q.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_resp_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
               e = q.pop_front();
               check("resp_word", resp_word, e.w0);
               check("resp_word_tie1", resp_word1, e.w1);
               check("timeout_err", timeout_err, e.terr);
               check("done_busy", busy, 1);
               check("word_latency", cyc, e.cyc);
               chk_after = 1;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; seed = 8'h00; fin_a = 1'b0; fin_b = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check("reset_busy", busy, 0);
      check("reset_clear", cnt_clear, 1);
      check("reset_run", cnt_run, 0);
      check("reset_chal", challenge, 0);
      check("reset_word", resp_word, 0);
      check("reset_terr", timeout_err, 0);
      check("reset_valid", resp_valid, 0);

      // A wins races 0,2; B wins 1,3
      rr[0] = mk(3, 1, 0, 0); rr[1] = mk(2, 0, 1, 0);
      rr[2] = mk(5, 1, 0, 0); rr[3] = mk(1, 0, 1, 0);
      run_word(8'h10, -1);

      // tie, timeout, A, tie
      rr[0] = mk(2, 1, 1, 0); rr[1] = mk(0, 0, 0, 0);
      rr[2] = mk(1, 1, 0, 0); rr[3] = mk(4, 1, 1, 0);
      run_word(8'h40, -1);

      // challenge wrap, stale fin_a during clear, A on the final allowed cycle
      rr[0] = mk(3, 0, 1, 1); rr[1] = mk(1, 1, 0, 0);
      rr[2] = mk(2, 0, 1, 1); rr[3] = mk(TO, 1, 0, 0);
      run_word(8'hFE, -1);

      // reset during race 2, start pulsed while busy
      rr[0] = mk(1, 1, 0, 0); rr[1] = mk(1, 0, 1, 0);
      rr[2] = mk(5, 1, 0, 0); rr[3] = mk(1, 1, 0, 0);
      run_word(8'h30, 2);

      rr[0] = mk(1, 1, 0, 0); rr[1] = mk(1, 1, 0, 0);
      rr[2] = mk(1, 1, 0, 0); rr[3] = mk(1, 1, 0, 0);
      run_word(8'h20, -1);

      repeat (5) step();
      check("queue_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
